// File: rtl/tswitch_pkg.sv
// Shared switch types and widths for the multicast store path.
package tswitch_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned TAG_WIDTH    = 8;
    localparam int unsigned MC_NUM_PORTS = 4;
    localparam int unsigned MC_PORT_BITS = $clog2(MC_NUM_PORTS);

    // Queued multicast request; mask/src_port are sized for the switch port count.
    typedef struct packed {
        logic [MC_NUM_PORTS-1:0] mask;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   data;
        logic [TAG_WIDTH-1:0]    tag;
        logic [MC_PORT_BITS-1:0] src_port;
    } mc_req_t;

endpackage

// File: rtl/mc_req_fifo.sv
// Synchronous FIFO of resolved multicast requests with occupancy and full flag.
module mc_req_fifo
    import tswitch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_BITS = $clog2(DEPTH),
    localparam int unsigned LVL_BITS = PTR_BITS + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  mc_req_t             din,
    input  logic                pop,
    output mc_req_t             head,
    output logic [LVL_BITS-1:0] level,
    output logic                full
);

    mc_req_t               mem_q [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q;
    logic [PTR_BITS-1:0]   rd_ptr_q;
    logic [LVL_BITS-1:0]   level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LVL_BITS'(DEPTH));

endmodule

// File: rtl/mc_group_dispatcher.sv
// Round-robin STORE_MC arbiter with group-table resolution and a request queue to the engine.
module mc_group_dispatcher
    import tswitch_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = MC_NUM_PORTS,
    parameter int unsigned NUM_GROUPS = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PORT_BITS  = $clog2(NUM_PORTS),
    localparam int unsigned GROUP_BITS = $clog2(NUM_GROUPS),
    localparam int unsigned LVL_BITS   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  req_valid,
    input  logic [NUM_PORTS-1:0][GROUP_BITS-1:0]  req_group,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]   req_tag,
    output logic [NUM_PORTS-1:0]                  req_ready,
    input  logic                                  cfg_we,
    input  logic [GROUP_BITS-1:0]                 cfg_group,
    input  logic [NUM_PORTS-1:0]                  cfg_mask,
    output logic                                  mc_valid,
    output logic [NUM_PORTS-1:0]                  mc_dst_mask,
    output logic [ADDR_WIDTH-1:0]                 mc_addr,
    output logic [DATA_WIDTH-1:0]                 mc_data,
    output logic [TAG_WIDTH-1:0]                  mc_tag,
    output logic [PORT_BITS-1:0]                  mc_src_port,
    input  logic                                  mc_ready,
    output logic                                  err_valid,
    output logic [TAG_WIDTH-1:0]                  err_tag,
    output logic [PORT_BITS-1:0]                  err_src_port,
    output logic [LVL_BITS-1:0]                   queue_level
);

    logic [NUM_GROUPS-1:0][NUM_PORTS-1:0] table_q;
    logic [PORT_BITS-1:0]                 rr_ptr_q;
    logic                                 err_valid_q;
    logic [TAG_WIDTH-1:0]                 err_tag_q;
    logic [PORT_BITS-1:0]                 err_src_q;

    logic                 full;
    logic                 gnt_any;
    logic [PORT_BITS-1:0] gnt_port;
    logic [PORT_BITS-1:0] idx;
    logic [NUM_PORTS-1:0] sel_mask;
    logic                 push;
    logic                 reject;
    logic                 pop;
    mc_req_t              push_req;
    mc_req_t              head;

    // First requester at or after rr_ptr, wrapping; suppressed entirely when full.
    always_comb begin
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_port  = '0;
        idx       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = PORT_BITS'((32'(rr_ptr_q) + 32'(i)) % NUM_PORTS);
            if (!gnt_any && !full && req_valid[idx]) begin
                req_ready[idx] = 1'b1;
                gnt_any        = 1'b1;
                gnt_port       = idx;
            end
        end
    end

    // Table read uses the registered contents, so a same-cycle cfg write is not visible.
    assign sel_mask = table_q[req_group[gnt_port]];
    assign push     = gnt_any && (sel_mask != '0);
    assign reject   = gnt_any && (sel_mask == '0);
    assign pop      = mc_valid && mc_ready;

    always_comb begin
        push_req          = '0;
        push_req.mask     = MC_NUM_PORTS'(sel_mask);
        push_req.addr     = req_addr[gnt_port];
        push_req.data     = req_data[gnt_port];
        push_req.tag      = req_tag[gnt_port];
        push_req.src_port = MC_PORT_BITS'(gnt_port);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q     <= '0;
            rr_ptr_q    <= '0;
            err_valid_q <= 1'b0;
            err_tag_q   <= '0;
            err_src_q   <= '0;
        end else begin
            if (cfg_we) begin
                table_q[cfg_group] <= cfg_mask;
            end
            if (gnt_any) begin
                rr_ptr_q <= (gnt_port == PORT_BITS'(NUM_PORTS - 1)) ? '0 : gnt_port + 1'b1;
            end
            err_valid_q <= reject;
            if (reject) begin
                err_tag_q <= req_tag[gnt_port];
                err_src_q <= gnt_port;
            end
        end
    end

    mc_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_req),
        .pop   (pop),
        .head  (head),
        .level (queue_level),
        .full  (full)
    );

    assign mc_valid     = (queue_level != '0);
    assign mc_dst_mask  = NUM_PORTS'(head.mask);
    assign mc_addr      = head.addr;
    assign mc_data      = head.data;
    assign mc_tag       = head.tag;
    assign mc_src_port  = PORT_BITS'(head.src_port);
    assign err_valid    = err_valid_q;
    assign err_tag      = err_tag_q;
    assign err_src_port = err_src_q;

endmodule

// File: tb/tb_mc_group_dispatcher.sv
// Directed table-driven bench for mc_group_dispatcher (4 ports, 8 groups, depth 4).
module tb_mc_group_dispatcher;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0][2:0]  req_group;
    logic [3:0][31:0] req_addr;
    logic [3:0][31:0] req_data;
    logic [3:0][7:0]  req_tag;
    logic [3:0]       req_ready;
    logic             cfg_we;
    logic [2:0]       cfg_group;
    logic [3:0]       cfg_mask;
    logic             mc_valid;
    logic [3:0]       mc_dst_mask;
    logic [31:0]      mc_addr;
    logic [31:0]      mc_data;
    logic [7:0]       mc_tag;
    logic [1:0]       mc_src_port;
    logic             mc_ready;
    logic             err_valid;
    logic [7:0]       err_tag;
    logic [1:0]       err_src_port;
    logic [2:0]       queue_level;

    always #5 clk = ~clk;

    mc_group_dispatcher dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_group    (req_group),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_tag      (req_tag),
        .req_ready    (req_ready),
        .cfg_we       (cfg_we),
        .cfg_group    (cfg_group),
        .cfg_mask     (cfg_mask),
        .mc_valid     (mc_valid),
        .mc_dst_mask  (mc_dst_mask),
        .mc_addr      (mc_addr),
        .mc_data      (mc_data),
        .mc_tag       (mc_tag),
        .mc_src_port  (mc_src_port),
        .mc_ready     (mc_ready),
        .err_valid    (err_valid),
        .err_tag      (err_tag),
        .err_src_port (err_src_port),
        .queue_level  (queue_level)
    );

    typedef struct {
        logic [3:0] rv;
        logic [2:0] g;
        logic       we;
        logic [2:0] cg;
        logic [3:0] cm;
        logic       rdy;
        logic [3:0] e_rr;
        logic       e_mv;
        logic [3:0] e_mask;
        logic [1:0] e_sp;
        logic       e_ev;
        logic [1:0] e_esp;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Fixed per-port payload: port p carries addr 0x40*p, data 0xD0+p, tag 4p+1.
    function automatic logic [7:0] tag_of(input logic [1:0] p);
        return 8'(4 * int'(p) + 1);
    endfunction

    function automatic logic [31:0] addr_of(input logic [1:0] p);
        return 32'h40 * 32'(p);
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic av(input logic [3:0] rv, input logic [2:0] g, input logic we,
                      input logic [2:0] cg, input logic [3:0] cm, input logic rdy,
                      input logic [3:0] e_rr, input logic e_mv, input logic [3:0] e_mask,
                      input logic [1:0] e_sp, input logic e_ev, input logic [1:0] e_esp,
                      input logic [2:0] e_lvl);
        vec_t v;
        v.rv = rv; v.g = g; v.we = we; v.cg = cg; v.cm = cm; v.rdy = rdy;
        v.e_rr = e_rr; v.e_mv = e_mv; v.e_mask = e_mask; v.e_sp = e_sp;
        v.e_ev = e_ev; v.e_esp = e_esp; v.e_lvl = e_lvl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] rv, input logic [2:0] g, input logic rdy);
        req_valid = rv;
        req_group = {4{g}};
        mc_ready  = rdy;
        cfg_we    = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_group = '0;
        cfg_we    = 1'b0;
        cfg_group = '0;
        cfg_mask  = '0;
        mc_ready  = 1'b0;
        for (int p = 0; p < 4; p++) begin
            req_addr[p] = addr_of(2'(p));
            req_data[p] = 32'hD0 + 32'(p);
            req_tag[p]  = tag_of(2'(p));
        end

        //  rv     g  we cg  cm     rdy  rr   mv mask  sp ev esp lvl
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 0 idle
        av(4'b0000, 0, 1, 3, 4'b0110, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 1 tbl[3]
        av(4'b0000, 0, 1, 1, 4'b1000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 2 tbl[1]
        av(4'b0000, 0, 1, 2, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 3 tbl[2]
        av(4'b0010, 3, 0, 0, 4'b0000, 1, 4'b0010, 0, 4'b0000, 0, 0, 0, 0); // 4 p1 g3
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b0110, 1, 0, 0, 1); // 5 N+1
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 6
        av(4'b1111, 2, 0, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 0, 0, 0, 0); // 7 rr from 2
        av(4'b1111, 2, 0, 0, 4'b0000, 1, 4'b1000, 1, 4'b1111, 2, 0, 0, 1); // 8
        av(4'b1111, 2, 0, 0, 4'b0000, 1, 4'b0001, 1, 4'b1111, 3, 0, 0, 1); // 9 wrap
        av(4'b1111, 2, 0, 0, 4'b0000, 1, 4'b0010, 1, 4'b1111, 0, 0, 0, 1); // 10
        av(4'b1111, 2, 0, 0, 4'b0000, 1, 4'b0100, 1, 4'b1111, 1, 0, 0, 1); // 11
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b1111, 2, 0, 0, 1); // 12
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 13
        av(4'b0100, 7, 0, 0, 4'b0000, 1, 4'b0100, 0, 4'b0000, 0, 0, 0, 0); // 14 p2 g7 empty
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 1, 2, 0); // 15 err pulse
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 16 pulse ends
        av(4'b1111, 2, 0, 0, 4'b0000, 1, 4'b1000, 0, 4'b0000, 0, 0, 0, 0); // 17 rr_ptr=3
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b1111, 3, 0, 0, 1); // 18
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 19
        av(4'b0001, 1, 1, 1, 4'b0001, 1, 4'b0001, 0, 4'b0000, 0, 0, 0, 0); // 20 req+cfg
        av(4'b0001, 1, 0, 0, 4'b0000, 1, 4'b0001, 1, 4'b1000, 0, 0, 0, 1); // 21 old mask
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b0001, 0, 0, 0, 1); // 22 new mask
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 23
        av(4'b0001, 3, 0, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000, 0, 0, 0, 0); // 24 fill
        av(4'b0001, 2, 0, 0, 4'b0000, 0, 4'b0001, 1, 4'b0110, 0, 0, 0, 1); // 25
        av(4'b0001, 1, 0, 0, 4'b0000, 0, 4'b0001, 1, 4'b0110, 0, 0, 0, 2); // 26
        av(4'b0001, 3, 0, 0, 4'b0000, 0, 4'b0001, 1, 4'b0110, 0, 0, 0, 3); // 27
        av(4'b0001, 2, 0, 0, 4'b0000, 0, 4'b0000, 1, 4'b0110, 0, 0, 0, 4); // 28 full
        av(4'b0001, 2, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b0110, 0, 0, 0, 4); // 29 no bypass
        av(4'b0001, 2, 0, 0, 4'b0000, 1, 4'b0001, 1, 4'b1111, 0, 0, 0, 3); // 30 5th in
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b0001, 0, 0, 0, 3); // 31
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b0110, 0, 0, 0, 2); // 32
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 1, 4'b1111, 0, 0, 0, 1); // 33 5th out
        av(4'b0000, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // 34 drained

        // Reset values while rst_n is held low
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", -1, 32'(req_ready), 32'h0);
        check("rst_mc_valid", -1, 32'(mc_valid), 32'h0);
        check("rst_err_valid", -1, 32'(err_valid), 32'h0);
        check("rst_level", -1, 32'(queue_level), 32'h0);
        check("rst_mask", -1, 32'(mc_dst_mask), 32'h0);
        check("rst_addr", -1, mc_addr, 32'h0);
        check("rst_tag", -1, 32'(mc_tag), 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            req_valid = vecs[k].rv;
            req_group = {4{vecs[k].g}};
            cfg_we    = vecs[k].we;
            cfg_group = vecs[k].cg;
            cfg_mask  = vecs[k].cm;
            mc_ready  = vecs[k].rdy;
            #1;
            check("req_ready", k, 32'(req_ready), 32'(vecs[k].e_rr));
            check("mc_valid", k, 32'(mc_valid), 32'(vecs[k].e_mv));
            check("queue_level", k, 32'(queue_level), 32'(vecs[k].e_lvl));
            check("err_valid", k, 32'(err_valid), 32'(vecs[k].e_ev));
            if (vecs[k].e_mv) begin
                check("mc_dst_mask", k, 32'(mc_dst_mask), 32'(vecs[k].e_mask));
                check("mc_src_port", k, 32'(mc_src_port), 32'(vecs[k].e_sp));
                check("mc_tag", k, 32'(mc_tag), 32'(tag_of(vecs[k].e_sp)));
                check("mc_addr", k, mc_addr, addr_of(vecs[k].e_sp));
            end
            if (vecs[k].e_ev) begin
                check("err_src_port", k, 32'(err_src_port), 32'(vecs[k].e_esp));
                check("err_tag", k, 32'(err_tag), 32'(tag_of(vecs[k].e_esp)));
            end
        end

        // Mid-operation reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(4'b0001, 3'd2, 1'b0);
        end
        @(negedge clk);
        drive(4'b0000, 3'd0, 1'b0);
        #1;
        check("pre_rst_level", 100, 32'(queue_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mc_valid", 100, 32'(mc_valid), 32'h0);
        check("mid_rst_level", 100, 32'(queue_level), 32'h0);
        check("mid_rst_mask", 100, 32'(mc_dst_mask), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(4'b0001, 3'd1, 1'b1);
        #1;
        check("post_rst_ready", 101, 32'(req_ready), 32'h1);
        @(negedge clk);
        drive(4'b0000, 3'd0, 1'b1);
        #1;
        check("post_rst_err_valid", 102, 32'(err_valid), 32'h1);
        check("post_rst_err_port", 102, 32'(err_src_port), 32'h0);
        check("post_rst_err_tag", 102, 32'(err_tag), 32'(tag_of(2'd0)));
        check("post_rst_mc_valid", 102, 32'(mc_valid), 32'h0);
        check("post_rst_level", 102, 32'(queue_level), 32'h0);
        @(negedge clk);
        #1;
        check("post_rst_err_end", 103, 32'(err_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
